seq_carry_skip_adder: RTL and testbench

- Multi-cycle carry-skip adder that processes one GROUP-bit block per clock, low group first.
- Each block is a ripple chain of existing FA cells, one per bit.
- Each FA's `propagate` is ANDed into a group propagate, which drives the skip multiplexer for that block's carry-out.
- Sits between the operand source and the result consumer, using a valid/ready handshake on both sides.

---
 rtl/seq_carry_skip_adder_pkg.sv | 21 ++
 rtl/seq_carry_skip_adder_csa_group_slice.sv | 49 ++++
 rtl/seq_carry_skip_adder.sv | 138 +++++++++++++
 tb/tb_seq_carry_skip_adder.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_carry_skip_adder_pkg.sv
// Shared types and sizing helpers for the sequential carry-skip adder.
package seq_carry_skip_adder_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_GROUP = 4;
  localparam int NG        = DEF_WIDTH / DEF_GROUP;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // A one-group adder still needs a 1-bit index register.
  function automatic int calc_idx_w(input int ng);
    return (ng > 1) ? $clog2(ng) : 1;
  endfunction

  localparam int IDX_W = calc_idx_w(NG);

endpackage

// File: rtl/seq_carry_skip_adder_csa_group_slice.sv
// One carry-skip block: a ripple chain of full-adder cells plus the group
// propagate that lets the caller bypass the chain for the block carry-out.
module csa_fa (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout,
  output logic o_propagate
);
  assign o_propagate = i_a ^ i_b;
  assign o_sum       = o_propagate ^ i_cin;
  assign o_cout      = (i_a & i_b) | (o_propagate & i_cin);
endmodule

module csa_group_slice
  import seq_carry_skip_adder_pkg::*;
#(
  parameter int GROUP = DEF_GROUP
) (
  input  logic [GROUP-1:0] i_a,
  input  logic [GROUP-1:0] i_b,
  input  logic             i_cin,
  output logic [GROUP-1:0] o_sum,
  output logic             o_cout_ripple,
  output logic             o_carry_msb,
  output logic             o_propagate
);
  logic [GROUP:0]   w_carry;
  logic [GROUP-1:0] w_prop;

  assign w_carry[0] = i_cin;

  for (genvar gi = 0; gi < GROUP; gi++) begin : g_fa
    csa_fa u_fa (
      .i_a        (i_a[gi]),
      .i_b        (i_b[gi]),
      .i_cin      (w_carry[gi]),
      .o_sum      (o_sum[gi]),
      .o_cout     (w_carry[gi+1]),
      .o_propagate(w_prop[gi])
    );
  end

  assign o_cout_ripple = w_carry[GROUP];
  // Carry into the top bit of the block; only meaningful for the last group.
  assign o_carry_msb   = w_carry[GROUP-1];
  assign o_propagate   = &w_prop;
endmodule

// File: rtl/seq_carry_skip_adder.sv
// Multi-cycle carry-skip adder: one GROUP-bit block per clock, low group first,
// with valid/ready handshakes on the operand and result sides.
module seq_carry_skip_adder
  import seq_carry_skip_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int GROUP = DEF_GROUP
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  input  logic                     cin,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         sum,
  output logic                     cout,
  output logic                     ovf,
  output logic [WIDTH/GROUP-1:0]   skip_flags
);
  localparam int NUM_GROUPS = WIDTH / GROUP;
  localparam int IDX_BITS   = calc_idx_w(NUM_GROUPS);

  if ((WIDTH % GROUP) != 0) begin : g_bad_group
    $error("WIDTH must be a multiple of GROUP");
  end

  state_e                  r_state;
  state_e                  w_state_next;
  logic [WIDTH-1:0]        r_a;
  logic [WIDTH-1:0]        r_b;
  logic                    r_carry;
  logic [IDX_BITS-1:0]     r_idx;
  logic [WIDTH-1:0]        r_sum;
  logic                    r_cout;
  logic                    r_ovf;
  logic [NUM_GROUPS-1:0]   r_skip;

  logic [GROUP-1:0]        w_grp_a;
  logic [GROUP-1:0]        w_grp_b;
  logic [GROUP-1:0]        w_grp_sum;
  logic                    w_ripple_cout;
  logic                    w_carry_msb;
  logic                    w_prop;
  logic                    w_grp_cout;
  logic                    w_last;

  assign w_grp_a    = r_a[r_idx*GROUP +: GROUP];
  assign w_grp_b    = r_b[r_idx*GROUP +: GROUP];
  assign w_last     = (r_idx == IDX_BITS'(NUM_GROUPS - 1));
  // Skip multiplexer: a fully propagating block passes its carry-in straight through.
  assign w_grp_cout = w_prop ? r_carry : w_ripple_cout;

  csa_group_slice #(
    .GROUP(GROUP)
  ) u_slice (
    .i_a          (w_grp_a),
    .i_b          (w_grp_b),
    .i_cin        (r_carry),
    .o_sum        (w_grp_sum),
    .o_cout_ripple(w_ripple_cout),
    .o_carry_msb  (w_carry_msb),
    .o_propagate  (w_prop)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_next = RUN;
      end
      RUN: begin
        if (w_last) w_state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_skip  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_idx   <= '0;
            r_skip  <= '0;
          end
        end
        RUN: begin
          r_sum[r_idx*GROUP +: GROUP] <= w_grp_sum;
          r_skip[r_idx]               <= w_prop;
          r_carry                     <= w_grp_cout;
          if (w_last) begin
            r_cout <= w_grp_cout;
            r_ovf  <= w_carry_msb ^ w_grp_cout;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum        = r_sum;
  assign cout       = r_cout;
  assign ovf        = r_ovf;
  assign skip_flags = r_skip;

endmodule

// File: tb/tb_seq_carry_skip_adder.sv
// Directed and randomised checks of the sequential carry-skip adder (16-bit, 4-bit groups).
module tb_seq_carry_skip_adder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;
  logic [3:0]  skip_flags;

  int checks   = 0;
  int failures = 0;

  seq_carry_skip_adder #(.WIDTH(16), .GROUP(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .skip_flags(skip_flags)
  );

  always #5 clk = ~clk;

  // Drives one transaction and returns the observed result; lat counts edges
  // from the accept edge to the first edge after which out_valid is high.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                        input logic keep_ready, output int lat, output logic [15:0] s,
                        output logic c, output logic o, output logic [3:0] sk,
                        output logic was_ready);
    @(negedge clk);
    a = ta; b = tb_v; cin = tc; in_valid = 1'b1;
    was_ready = in_ready;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    s = sum; c = cout; o = ovf; sk = skip_flags;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = keep_ready;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, out_valid, sum, cout, ovf, skip_flags} !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 4'h0}) begin
      failures++;
      $display("FAIL reset_values: in_ready=%b out_valid=%b sum=%h cout=%b ovf=%b skip=%b required 1 0 0000 0 0 0000",
               in_ready, out_valid, sum, cout, ovf, skip_flags);
    end
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL idle_out_ready: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
    end
    out_ready = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_basic();
    logic [15:0] ta [3];
    logic [15:0] tb_v [3];
    logic        tc [3];
    logic [15:0] es [3];
    logic        ec [3];
    logic        eo [3];
    logic [3:0]  esk [3];
    int lat; logic [15:0] s; logic c, o, rdy; logic [3:0] sk;
    ta[0] = 16'hFFFF; tb_v[0] = 16'h0001; tc[0] = 1'b0; es[0] = 16'h0000; ec[0] = 1'b1; eo[0] = 1'b0; esk[0] = 4'b1110;
    ta[1] = 16'h1234; tb_v[1] = 16'h4321; tc[1] = 1'b1; es[1] = 16'h5556; ec[1] = 1'b0; eo[1] = 1'b0; esk[1] = 4'b0000;
    // 0x7FFF^0x0001 = 0x7FFE: only the two middle groups fully propagate.
    ta[2] = 16'h7FFF; tb_v[2] = 16'h0001; tc[2] = 1'b0; es[2] = 16'h8000; ec[2] = 1'b0; eo[2] = 1'b1; esk[2] = 4'b0110;
    for (int i = 0; i < 3; i++) begin
      run_op(ta[i], tb_v[i], tc[i], 1'b0, lat, s, c, o, sk, rdy);
      checks++;
      if ({s, c, o, sk} !== {es[i], ec[i], eo[i], esk[i]}) begin
        failures++;
        $display("FAIL basic_%0d: sum=%h cout=%b ovf=%b skip=%b required %h %b %b %b",
                 i, s, c, o, sk, es[i], ec[i], eo[i], esk[i]);
      end
      checks++;
      if (lat !== 4 || rdy !== 1'b1) begin
        failures++;
        $display("FAIL latency_%0d: edges=%0d in_ready=%b required 4 1", i, lat, rdy);
      end
      $display("basic %0d: a=%h b=%h cin=%b -> sum=%h cout=%b ovf=%b skip=%b", i, ta[i], tb_v[i], tc[i], s, c, o, sk);
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    a = 16'h1234; b = 16'h4321; cin = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
        failures++;
        $display("FAIL run_handshake_%0d: in_ready=%b out_valid=%b required 0 0", i, in_ready, out_valid);
      end
      in_valid = ~in_valid;
      @(posedge clk);
      @(negedge clk);
    end
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL done_reached: out_valid=%b required 1", out_valid);
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({out_valid, in_ready, sum, cout, ovf, skip_flags} !== {1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 4'b0000}) begin
        failures++;
        $display("FAIL hold_%0d: out_valid=%b in_ready=%b sum=%h cout=%b ovf=%b skip=%b required 1 0 5556 0 0 0000",
                 i, out_valid, in_ready, sum, cout, ovf, skip_flags);
      end
    end
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL release: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || sum !== 16'h5556) begin
      failures++;
      $display("FAIL no_stray_accept: in_ready=%b sum=%h required 1 5556", in_ready, sum);
    end
    $display("backpressure: held 5 cycles, sum=%h", sum);
  endtask

  task automatic test_reset_mid_run();
    int lat; logic [15:0] s; logic c, o, rdy; logic [3:0] sk;
    @(negedge clk);
    a = 16'hFFFF; b = 16'h0000; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    checks++;
    if (skip_flags !== 4'b0011 || sum[7:0] !== 8'hFF || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL partial_run: skip=%b sum_lo=%h in_ready=%b required 0011 ff 0", skip_flags, sum[7:0], in_ready);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, sum, cout, ovf, skip_flags} !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 4'h0}) begin
      failures++;
      $display("FAIL mid_reset: in_ready=%b out_valid=%b sum=%h cout=%b ovf=%b skip=%b required 1 0 0000 0 0 0000",
               in_ready, out_valid, sum, cout, ovf, skip_flags);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        failures++;
        $display("FAIL post_reset_idle: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
      end
    end
    run_op(16'h00FF, 16'hFF01, 1'b0, 1'b0, lat, s, c, o, sk, rdy);
    // 0x00FF^0xFF01 = 0xFFFE: the upper three groups fully propagate.
    checks++;
    if ({s, c, o, sk} !== {16'h0000, 1'b1, 1'b0, 4'b1110} || lat !== 4) begin
      failures++;
      $display("FAIL after_reset_op: sum=%h cout=%b ovf=%b skip=%b edges=%0d required 0000 1 0 1110 4",
               s, c, o, sk, lat);
    end
    $display("reset_mid_run: recovered sum=%h cout=%b skip=%b", s, c, sk);
  endtask

  task automatic test_back_to_back();
    int lat; logic [15:0] s; logic c, o, rdy; logic [3:0] sk;
    logic [15:0] ra, rb, x, es; logic rc, ec, eo; logic [3:0] esk; logic [16:0] full;
    out_ready = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom_range(0, 1));
      if (n == 0) begin ra = 16'h8000; rb = 16'h8000; rc = 1'b0; end
      if (n == 1) begin ra = 16'hAAAA; rb = 16'h5555; rc = 1'b1; end
      full = {1'b0, ra} + {1'b0, rb} + {16'h0, rc};
      es = full[15:0];
      ec = full[16];
      eo = (ra[15] == rb[15]) && (es[15] != ra[15]);
      x = ra ^ rb;
      for (int g = 0; g < 4; g++) esk[g] = &x[g*4 +: 4];
      run_op(ra, rb, rc, 1'b1, lat, s, c, o, sk, rdy);
      checks++;
      if ({s, c, o, sk} !== {es, ec, eo, esk} || lat !== 4 || rdy !== 1'b1) begin
        failures++;
        $display("FAIL random_%0d: a=%h b=%h cin=%b sum=%h cout=%b ovf=%b skip=%b edges=%0d required %h %b %b %b 4",
                 n, ra, rb, rc, s, c, o, sk, lat, es, ec, eo, esk);
      end
      if (n < 4) $display("random %0d: a=%h b=%h cin=%b -> sum=%h cout=%b ovf=%b skip=%b", n, ra, rb, rc, s, c, o, sk);
    end
    out_ready = 1'b0;
    $display("back_to_back: 1000 operations done");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
